// File: rtl/frame_buf_addr_gen.sv
// Burst address generator for a multi-buffered video frame store.
// Steps by burst within a line, by line stride at line end, and rotates buffers at frame end.
module frame_buf_addr_gen #(
  parameter int unsigned ASIZE          = 29,
  parameter int unsigned BURST_MAP_ADDR = 12800,
  parameter int unsigned LSIZE          = 12,
  parameter int unsigned NUM_BUFS       = 3,
  parameter int unsigned BSIZE          = 2
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             new_base,
  input  logic [ASIZE-1:0] baseaddr,
  input  logic [ASIZE-1:0] frame_stride,
  input  logic [ASIZE-1:0] line_stride,
  input  logic [LSIZE-1:0] vactive,
  input  logic             burst_done,
  input  logic             tail_done,
  output logic [ASIZE-1:0] out_addr,
  output logic [LSIZE-1:0] line_cnt,
  output logic [BSIZE-1:0] buf_idx,
  output logic             line_done,
  output logic             frame_done
);

  localparam logic [ASIZE-1:0] BurstInc = ASIZE'(BURST_MAP_ADDR);
  localparam logic [BSIZE-1:0] LastBuf  = BSIZE'(NUM_BUFS - 1);

  logic [ASIZE-1:0] base_l, fstride_l, lstride_l;
  logic [LSIZE-1:0] vact_l;
  logic [ASIZE-1:0] frame_base, line_start, curr;
  logic             burst_d, tail_d;

  logic             rise_b, rise_t;
  logic [LSIZE-1:0] vact_eff;
  logic             last_line, last_buf;
  logic [ASIZE-1:0] next_frame_base, next_line_start;

  always_comb begin
    rise_b          = burst_done & ~burst_d;
    rise_t          = tail_done & ~tail_d;
    // A zero line count would never reach its last line, so treat it as one line.
    vact_eff        = (vact_l == '0) ? LSIZE'(1) : vact_l;
    last_line       = (line_cnt == vact_eff - LSIZE'(1));
    last_buf        = (buf_idx == LastBuf);
    next_frame_base = last_buf ? base_l : frame_base + fstride_l;
    next_line_start = line_start + lstride_l;
  end

  assign out_addr = curr;

  always_ff @(posedge clock) begin
    if (rst) begin
      base_l     <= '0;
      fstride_l  <= '0;
      lstride_l  <= '0;
      vact_l     <= '0;
      frame_base <= '0;
      line_start <= '0;
      curr       <= '0;
      line_cnt   <= '0;
      buf_idx    <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      burst_d    <= 1'b0;
      tail_d     <= 1'b0;
    end else begin
      burst_d    <= burst_done;
      tail_d     <= tail_done;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      if (new_base) begin
        base_l     <= baseaddr;
        fstride_l  <= frame_stride;
        lstride_l  <= line_stride;
        vact_l     <= vactive;
        frame_base <= baseaddr;
        line_start <= baseaddr;
        curr       <= baseaddr;
        line_cnt   <= '0;
        buf_idx    <= '0;
      end else if (rise_t) begin
        // Tail wins over a coincident burst edge; that burst increment is dropped.
        line_done <= 1'b1;
        if (last_line) begin
          frame_done <= 1'b1;
          line_cnt   <= '0;
          buf_idx    <= last_buf ? '0 : buf_idx + BSIZE'(1);
          frame_base <= next_frame_base;
          line_start <= next_frame_base;
          curr       <= next_frame_base;
        end else begin
          line_cnt   <= line_cnt + LSIZE'(1);
          line_start <= next_line_start;
          curr       <= next_line_start;
        end
      end else if (rise_b) begin
        curr <= curr + BurstInc;
      end
    end
  end

endmodule

// File: tb/tb_frame_buf_addr_gen.sv
// Directed self-checking bench for frame_buf_addr_gen with default parameters.
module tb_frame_buf_addr_gen;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        new_base = 1'b0;
  logic [28:0] baseaddr = 29'h100000;
  logic [28:0] frame_stride = 29'h200000;
  logic [28:0] line_stride = 29'h4000;
  logic [11:0] vactive = 12'd3;
  logic        burst_done = 1'b0;
  logic        tail_done = 1'b0;
  logic [28:0] out_addr;
  logic [11:0] line_cnt;
  logic [1:0]  buf_idx;
  logic        line_done;
  logic        frame_done;

  int total = 0;
  int bad = 0;

  frame_buf_addr_gen dut (
    .clock        (clock),
    .rst          (rst),
    .new_base     (new_base),
    .baseaddr     (baseaddr),
    .frame_stride (frame_stride),
    .line_stride  (line_stride),
    .vactive      (vactive),
    .burst_done   (burst_done),
    .tail_done    (tail_done),
    .out_addr     (out_addr),
    .line_cnt     (line_cnt),
    .buf_idx      (buf_idx),
    .line_done    (line_done),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_new_base();
    new_base = 1'b1;
    tick();
    new_base = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({out_addr, line_cnt, buf_idx, line_done, frame_done} !== '0) begin
      bad++;
      $display("FAIL reset_state: addr=%h line=%0d buf=%0d ld=%b fd=%b, want all zero",
               out_addr, line_cnt, buf_idx, line_done, frame_done);
    end
  endtask

  task automatic test_burst();
    do_new_base();
    total++;
    if (out_addr !== 29'h100000 || line_cnt !== 12'd0 || buf_idx !== 2'd0) begin
      bad++;
      $display("FAIL new_base: addr=%h line=%0d buf=%0d, want 100000/0/0",
               out_addr, line_cnt, buf_idx);
    end
    burst_done = 1'b1; tick(); burst_done = 1'b0;
    total++;
    if (out_addr !== 29'h103200) begin
      bad++; $display("FAIL burst1: addr=%h want 103200", out_addr);
    end
    tick();
    burst_done = 1'b1; tick(); burst_done = 1'b0; tick();
    total++;
    if (out_addr !== 29'h106400) begin
      bad++; $display("FAIL burst2: addr=%h want 106400", out_addr);
    end
    burst_done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    burst_done = 1'b0;
    tick();
    total++;
    if (out_addr !== 29'h109600) begin
      bad++; $display("FAIL burst_level: addr=%h want 109600", out_addr);
    end
  endtask

  task automatic test_tail();
    tail_done = 1'b1; tick(); tail_done = 1'b0;
    total++;
    if (out_addr !== 29'h104000 || line_cnt !== 12'd1 || line_done !== 1'b1
        || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL tail_line: addr=%h line=%0d ld=%b fd=%b, want 104000/1/1/0",
               out_addr, line_cnt, line_done, frame_done);
    end
    tick();
    total++;
    if (line_done !== 1'b0) begin
      bad++; $display("FAIL line_done_width: ld=%b want 0", line_done);
    end
  endtask

  task automatic test_frame();
    tail_done = 1'b1; tick(); tail_done = 1'b0; tick();
    total++;
    if (out_addr !== 29'h108000 || line_cnt !== 12'd2) begin
      bad++; $display("FAIL tail_line2: addr=%h line=%0d want 108000/2", out_addr, line_cnt);
    end
    tail_done = 1'b1; tick(); tail_done = 1'b0;
    total++;
    if (frame_done !== 1'b1 || line_done !== 1'b1 || buf_idx !== 2'd1
        || out_addr !== 29'h300000 || line_cnt !== 12'd0) begin
      bad++;
      $display("FAIL frame_end: fd=%b ld=%b buf=%0d addr=%h line=%0d, want 1/1/1/300000/0",
               frame_done, line_done, buf_idx, out_addr, line_cnt);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      tail_done = 1'b1; tick(); tail_done = 1'b0; tick();
    end
    total++;
    if (buf_idx !== 2'd0 || out_addr !== 29'h100000 || line_cnt !== 12'd0) begin
      bad++;
      $display("FAIL buf_wrap: buf=%0d addr=%h line=%0d, want 0/100000/0",
               buf_idx, out_addr, line_cnt);
    end
  endtask

  task automatic test_simultaneous();
    burst_done = 1'b1; tail_done = 1'b1; tick();
    burst_done = 1'b0; tail_done = 1'b0; tick();
    total++;
    if (out_addr !== 29'h104000 || line_cnt !== 12'd1) begin
      bad++;
      $display("FAIL simul_tail_burst: addr=%h line=%0d, want 104000/1", out_addr, line_cnt);
    end
  endtask

  task automatic test_newbase_collision();
    tail_done = 1'b1; tick(); tail_done = 1'b0; tick();
    baseaddr = 29'h040000;
    new_base = 1'b1; tail_done = 1'b1; tick();
    new_base = 1'b0; tail_done = 1'b0;
    total++;
    if (buf_idx !== 2'd0 || out_addr !== 29'h040000 || frame_done !== 1'b0
        || line_done !== 1'b0 || line_cnt !== 12'd0) begin
      bad++;
      $display("FAIL newbase_vs_tail: buf=%0d addr=%h fd=%b ld=%b line=%0d, want 0/040000/0/0/0",
               buf_idx, out_addr, frame_done, line_done, line_cnt);
    end
    tick();
    // Unlatched config changes must not affect the running frame.
    baseaddr = 29'h1234000; line_stride = 29'h10; frame_stride = 29'h20;
    for (int i = 0; i < 3; i++) begin
      tail_done = 1'b1; tick(); tail_done = 1'b0; tick();
    end
    total++;
    if (buf_idx !== 2'd1 || out_addr !== 29'h240000) begin
      bad++;
      $display("FAIL config_no_latch: buf=%0d addr=%h, want 1/240000", buf_idx, out_addr);
    end
    baseaddr = 29'h100000; line_stride = 29'h4000; frame_stride = 29'h200000;
  endtask

  task automatic test_vactive_zero();
    vactive = 12'd0;
    do_new_base();
    tail_done = 1'b1; tick(); tail_done = 1'b0;
    total++;
    if (frame_done !== 1'b1 || buf_idx !== 2'd1 || out_addr !== 29'h300000) begin
      bad++;
      $display("FAIL vact0_first: fd=%b buf=%0d addr=%h, want 1/1/300000",
               frame_done, buf_idx, out_addr);
    end
    tick();
    tail_done = 1'b1; tick(); tail_done = 1'b0;
    total++;
    if (frame_done !== 1'b1 || buf_idx !== 2'd2 || out_addr !== 29'h500000) begin
      bad++;
      $display("FAIL vact0_second: fd=%b buf=%0d addr=%h, want 1/2/500000",
               frame_done, buf_idx, out_addr);
    end
    tick();
    vactive = 12'd3;
  endtask

  task automatic test_addr_wrap();
    baseaddr = 29'h1FFFFFF0;
    do_new_base();
    burst_done = 1'b1; tick(); burst_done = 1'b0; tick();
    total++;
    if (out_addr !== 29'h000031F0) begin
      bad++; $display("FAIL addr_wrap: addr=%h want 000031f0", out_addr);
    end
    baseaddr = 29'h100000;
  endtask

  task automatic test_reset_mid();
    do_new_base();
    burst_done = 1'b1; tick();
    tail_done = 1'b1; tick();
    rst = 1'b1; tick(); tick();
    rst = 1'b0; burst_done = 1'b0; tail_done = 1'b0;
    total++;
    if ({out_addr, line_cnt, buf_idx, line_done, frame_done} !== '0) begin
      bad++;
      $display("FAIL reset_mid: addr=%h line=%0d buf=%0d ld=%b fd=%b, want all zero",
               out_addr, line_cnt, buf_idx, line_done, frame_done);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_tail();
    test_frame();
    test_simultaneous();
    test_newbase_collision();
    test_vactive_zero();
    test_addr_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
